// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle ARM-subset controller: FSM states,
// datapath select codes, condition codes and data-processing commands.
package mc_ctrl_pkg;

   localparam int unsigned INSTR_W = 20;
   localparam int unsigned FLAGS_W = 4;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'h0,
      ST_DECODE   = 4'h1,
      ST_MEMADR   = 4'h2,
      ST_MEMREAD  = 4'h3,
      ST_MEMWB    = 4'h4,
      ST_MEMWRITE = 4'h5,
      ST_EXECUTER = 4'h6,
      ST_EXECUTEI = 4'h7,
      ST_ALUWB    = 4'h8,
      ST_BRANCH   = 4'h9,
      ST_FAULT    = 4'hF
   } state_e;

   localparam logic [1:0] SRCA_RN    = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;
   localparam logic [1:0] SRCB_RM    = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] IMM_DP     = 2'b00;
   localparam logic [1:0] IMM_MEM    = 2'b01;
   localparam logic [1:0] IMM_BR     = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   localparam logic [3:0] CMD_SUB = 4'h2;
   localparam logic [3:0] CMD_RSB = 4'h3;
   localparam logic [3:0] CMD_ADD = 4'h4;
   localparam logic [3:0] CMD_ADC = 4'h5;
   localparam logic [3:0] CMD_SBC = 4'h6;
   localparam logic [3:0] CMD_TST = 4'h8;
   localparam logic [3:0] CMD_TEQ = 4'h9;
   localparam logic [3:0] CMD_CMP = 4'hA;
   localparam logic [3:0] CMD_CMN = 4'hB;

   // Commands whose carry/overflow outputs are meaningful
   function automatic logic is_arith(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_ADC) || (cmd == CMD_SUB) ||
             (cmd == CMD_SBC) || (cmd == CMD_RSB) || (cmd == CMD_CMP) ||
             (cmd == CMD_CMN);
   endfunction

   // Compare/test commands only set flags and never write Rd
   function automatic logic is_test(input logic [3:0] cmd);
      return (cmd == CMD_TST) || (cmd == CMD_TEQ) || (cmd == CMD_CMP) ||
             (cmd == CMD_CMN);
   endfunction

endpackage

// File: rtl/mc_cond_check.sv
// ARM condition-code evaluation against the current NZCV flags.
module mc_cond_check
   import mc_ctrl_pkg::*;
(
   input  logic [3:0]         cond_i,
   input  logic [FLAGS_W-1:0] flags_i,
   output logic               cond_ex_o
);

   logic n, z, c, v;
   assign {n, z, c, v} = flags_i;

   // Code 4'hF shares the AL behaviour through the default branch
   always_comb begin
      cond_ex_o = 1'b1;
      case (cond_i)
         COND_EQ: cond_ex_o = z;
         COND_NE: cond_ex_o = ~z;
         COND_CS: cond_ex_o = c;
         COND_CC: cond_ex_o = ~c;
         COND_MI: cond_ex_o = n;
         COND_PL: cond_ex_o = ~n;
         COND_VS: cond_ex_o = v;
         COND_VC: cond_ex_o = ~v;
         COND_HI: cond_ex_o = c & ~z;
         COND_LS: cond_ex_o = ~c | z;
         COND_GE: cond_ex_o = (n == v);
         COND_LT: cond_ex_o = (n != v);
         COND_GT: cond_ex_o = ~z & (n == v);
         COND_LE: cond_ex_o = z | (n != v);
         COND_AL: cond_ex_o = 1'b1;
         default: cond_ex_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_controller_ws.sv
// Multi-cycle ARM-subset control unit with memory wait states, a bounded
// wait timeout and a sticky fault state for timeouts and undefined ops.
module mc_controller_ws
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TIMEOUT_W   = 5,
   parameter logic [3:0]  FLAG_RESET  = 4'b0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] Instr,
   input  logic [FLAGS_W-1:0] ALUFlags,
   input  logic               MemReady,
   output logic               MemReq,
   output logic               PCWrite,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic               IRWrite,
   output logic               AdrSrc,
   output logic [1:0]         RegSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ImmSrc,
   output logic [3:0]         ALUControl,
   output logic               Fault,
   output logic [3:0]         State
);

   state_e               state_q, state_d;
   logic [FLAGS_W-1:0]   flags_q, flags_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic                 cond_ex_q, cond_ex_d;
   logic                 cond_ex;
   logic                 mem_wait;
   logic                 reg_w, pcs, next_pc;

   // Instr holds bits [31:12] of the instruction word
   logic [3:0] cond, cmd, rd;
   logic [1:0] op;
   logic       i_bit, s_bit, l_bit;
   logic       unused_rn;
   assign cond      = Instr[19:16];
   assign op        = Instr[15:14];
   assign i_bit     = Instr[13];
   assign cmd       = Instr[12:9];
   assign s_bit     = Instr[8];
   assign l_bit     = Instr[8];
   assign unused_rn = ^Instr[7:4];
   assign rd        = Instr[3:0];

   mc_cond_check u_cond_check (
      .cond_i    (cond),
      .flags_i   (flags_q),
      .cond_ex_o (cond_ex)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_FETCH;
         flags_q   <= FLAG_RESET;
         cnt_q     <= '0;
         cond_ex_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         cnt_q     <= cnt_d;
         cond_ex_q <= cond_ex_d;
      end
   end

   // Next state, flag update and memory wait counter
   always_comb begin
      state_d   = state_q;
      flags_d   = flags_q;
      cond_ex_d = cond_ex_q;
      cnt_d     = '0;
      mem_wait  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (MemReady) state_d = ST_DECODE;
            else          mem_wait = 1'b1;
         end
         ST_DECODE: begin
            cond_ex_d = cond_ex;
            case (op)
               OP_DP:   state_d = i_bit ? ST_EXECUTEI : ST_EXECUTER;
               OP_MEM:  state_d = ST_MEMADR;
               OP_BR:   state_d = ST_BRANCH;
               default: state_d = ST_FAULT;
            endcase
         end
         ST_MEMADR: state_d = l_bit ? ST_MEMREAD : ST_MEMWRITE;
         ST_MEMREAD: begin
            if (MemReady) state_d = ST_MEMWB;
            else          mem_wait = 1'b1;
         end
         ST_MEMWRITE: begin
            if (MemReady) state_d = ST_FETCH;
            else          mem_wait = 1'b1;
         end
         ST_EXECUTER, ST_EXECUTEI: begin
            state_d = ST_ALUWB;
            if (s_bit && cond_ex_q) begin
               flags_d[3:2] = ALUFlags[3:2];
               if (is_arith(cmd)) flags_d[1:0] = ALUFlags[1:0];
            end
         end
         ST_MEMWB, ST_ALUWB, ST_BRANCH: state_d = ST_FETCH;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_FAULT;
      endcase
      // A ready in the last allowed cycle still advances normally
      if (mem_wait) begin
         cnt_d = cnt_q + TIMEOUT_W'(1);
         if ((MEM_TIMEOUT != 0) && (cnt_q == TIMEOUT_W'(MEM_TIMEOUT - 1)))
            state_d = ST_FAULT;
      end
   end

   // Output decode; memory strobes are also gated by reset so they drop at once
   always_comb begin
      MemReq     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = SRCA_RN;
      ALUSrcB    = SRCB_RM;
      ResultSrc  = RES_ALUOUT;
      ALUControl = CMD_ADD;
      RegSrc     = 2'b00;
      ImmSrc     = IMM_DP;
      reg_w      = 1'b0;
      pcs        = 1'b0;
      next_pc    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            MemReq    = reset;
            IRWrite   = MemReady & reset;
            next_pc   = MemReady & reset;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
         end
         ST_DECODE: begin
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
         end
         ST_MEMADR: ALUSrcB = SRCB_IMM;
         ST_MEMREAD: begin
            MemReq = reset;
            AdrSrc = 1'b1;
         end
         ST_MEMWB: begin
            ResultSrc = RES_DATA;
            reg_w     = 1'b1;
            pcs       = (rd == 4'hF);
         end
         ST_MEMWRITE: begin
            MemReq   = reset;
            MemWrite = cond_ex_q & reset;
            AdrSrc   = 1'b1;
         end
         ST_EXECUTER: ALUControl = cmd;
         ST_EXECUTEI: begin
            ALUSrcB    = SRCB_IMM;
            ALUControl = cmd;
         end
         ST_ALUWB: begin
            reg_w = ~is_test(cmd);
            pcs   = (rd == 4'hF);
         end
         ST_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURES;
            pcs       = 1'b1;
         end
         default: ;
      endcase
      if (state_q != ST_FAULT) begin
         RegSrc = {op == OP_MEM, op == OP_BR};
         case (op)
            OP_MEM:  ImmSrc = IMM_MEM;
            OP_BR:   ImmSrc = IMM_BR;
            default: ImmSrc = IMM_DP;
         endcase
      end
   end

   assign RegWrite = reg_w & cond_ex_q;
   assign PCWrite  = next_pc | (pcs & cond_ex_q);
   assign Fault    = (state_q == ST_FAULT);
   assign State    = state_q;

endmodule

// File: tb/tb_mc_controller_ws.sv
// Directed bench for mc_controller_ws: DP, load/store, branch, flags,
// wait states, timeout fault, undefined op and mid-access reset.
module tb_mc_controller_ws;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;
   logic        MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [3:0]  ALUControl, State;
   logic        Fault;

   int n_cmp = 0;
   int n_err = 0;

   mc_controller_ws #(
      .MEM_TIMEOUT (4),
      .TIMEOUT_W   (5),
      .FLAG_RESET  (4'b0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ALUFlags   (ALUFlags),
      .MemReady   (MemReady),
      .MemReq     (MemReq),
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .RegSrc     (RegSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .Fault      (Fault),
      .State      (State)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $error("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then drive inputs for the newly entered state
   task automatic nxt(input logic mr, input logic [3:0] fl);
      @(posedge clk);
      #1;
      MemReady = mr;
      ALUFlags = fl;
      #1;
   endtask

   task automatic release_reset(input logic mr);
      repeat (2) @(posedge clk);
      #3;
      MemReady = mr;
      reset    = 1'b1;
      #1;
   endtask

   task automatic run_subs(input logic [3:0] fl);
      Instr = 20'hE0511;
      nxt(1'b1, 4'hF);
      chk("subs_decode", State, 4'h1);
      nxt(1'b1, fl);
      chk("subs_exec", State, 4'h6);
      chk("subs_aluctl", ALUControl, 4'b0010);
      nxt(1'b1, 4'hF);
      chk("subs_aluwb_regw", RegWrite, 1'b1);
      nxt(1'b1, 4'hF);
      chk("subs_fetch", State, 4'h0);
   endtask

   task automatic run_beq(input logic exp_pcw);
      Instr = 20'h0A000;
      nxt(1'b1, 4'hF);
      chk("beq_decode", State, 4'h1);
      nxt(1'b1, 4'hF);
      chk("beq_state", State, 4'h9);
      chk("beq_pcwrite", PCWrite, exp_pcw);
      chk("beq_immsrc", ImmSrc, 2'b10);
      chk("beq_regsrc", RegSrc, 2'b01);
      nxt(1'b1, 4'hF);
      chk("beq_fetch", State, 4'h0);
   endtask

   initial begin
      reset    = 1'b0;
      MemReady = 1'b0;
      Instr    = '0;
      ALUFlags = 4'hF;
      #1;
      chk("rst_state", State, 4'h0);
      chk("rst_memreq", MemReq, 1'b0);
      chk("rst_pcwrite", PCWrite, 1'b0);
      chk("rst_regwrite", RegWrite, 1'b0);
      chk("rst_fault", Fault, 1'b0);
      MemReady = 1'b1;
      #1;
      chk("rst_irwrite_ready", IRWrite, 1'b0);
      release_reset(1'b1);

      // ADD R1,R2,R3
      Instr = 20'hE0821;
      #1;
      chk("add_fetch_state", State, 4'h0);
      chk("add_fetch_irwrite", IRWrite, 1'b1);
      chk("add_fetch_pcwrite", PCWrite, 1'b1);
      chk("add_fetch_memreq", MemReq, 1'b1);
      nxt(1'b1, 4'hF);
      chk("add_decode", State, 4'h1);
      chk("add_decode_regw", RegWrite, 1'b0);
      nxt(1'b1, 4'hF);
      chk("add_exec", State, 4'h6);
      chk("add_exec_aluctl", ALUControl, 4'b0100);
      chk("add_exec_regw", RegWrite, 1'b0);
      nxt(1'b1, 4'hF);
      chk("add_aluwb", State, 4'h8);
      chk("add_aluwb_regw", RegWrite, 1'b1);
      chk("add_aluwb_pcw", PCWrite, 1'b0);
      nxt(1'b1, 4'hF);
      chk("add_fetch_again", State, 4'h0);

      // LDR with three wait cycles in MEMREAD
      Instr = 20'hE5921;
      nxt(1'b1, 4'hF);
      chk("ldr_decode", State, 4'h1);
      nxt(1'b1, 4'hF);
      chk("ldr_memadr", State, 4'h2);
      chk("ldr_memadr_srcb", ALUSrcB, 2'b01);
      chk("ldr_memadr_imm", ImmSrc, 2'b01);
      for (int i = 0; i < 3; i++) begin
         nxt(1'b0, 4'hF);
         chk("ldr_memread_wait", State, 4'h3);
         chk("ldr_memread_req", MemReq, 1'b1);
         chk("ldr_memread_regw", RegWrite, 1'b0);
         chk("ldr_memread_adr", AdrSrc, 1'b1);
      end
      nxt(1'b1, 4'hF);
      chk("ldr_memread_last", State, 4'h3);
      chk("ldr_memread_last_req", MemReq, 1'b1);
      nxt(1'b1, 4'hF);
      chk("ldr_memwb", State, 4'h4);
      chk("ldr_memwb_regw", RegWrite, 1'b1);
      chk("ldr_memwb_res", ResultSrc, 2'b01);
      nxt(1'b1, 4'hF);
      chk("ldr_fetch", State, 4'h0);
      chk("ldr_fetch_regw", RegWrite, 1'b0);

      // SUBS sets Z, BEQ taken; SUBS clears Z, BEQ not taken
      run_subs(4'b0110);
      run_beq(1'b1);
      run_subs(4'b0010);
      run_beq(1'b0);

      // ADDNE with Z=1 must neither write nor touch flags
      run_subs(4'b0100);
      Instr = 20'h10821;
      nxt(1'b1, 4'hF);
      chk("addne_decode", State, 4'h1);
      nxt(1'b1, 4'b0000);
      chk("addne_exec", State, 4'h6);
      nxt(1'b1, 4'hF);
      chk("addne_aluwb", State, 4'h8);
      chk("addne_regw", RegWrite, 1'b0);
      chk("addne_pcw", PCWrite, 1'b0);
      nxt(1'b1, 4'hF);
      chk("addne_fetch", State, 4'h0);
      run_beq(1'b1);

      // Reset pulled low mid-MEMWRITE
      Instr = 20'hE5821;
      nxt(1'b1, 4'hF);
      nxt(1'b1, 4'hF);
      chk("str_memadr", State, 4'h2);
      nxt(1'b0, 4'hF);
      chk("str_memwrite", State, 4'h5);
      chk("str_memwrite_we", MemWrite, 1'b1);
      chk("str_memwrite_req", MemReq, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      chk("str_rst_we", MemWrite, 1'b0);
      chk("str_rst_req", MemReq, 1'b0);
      chk("str_rst_state", State, 4'h0);
      release_reset(1'b1);
      run_beq(1'b0);

      // Undefined op class goes to FAULT and stays there
      Instr = 20'hEC000;
      nxt(1'b1, 4'hF);
      nxt(1'b1, 4'hF);
      chk("undef_state", State, 4'hF);
      chk("undef_fault", Fault, 1'b1);
      chk("undef_memreq", MemReq, 1'b0);
      chk("undef_irwrite", IRWrite, 1'b0);
      chk("undef_pcwrite", PCWrite, 1'b0);
      chk("undef_regwrite", RegWrite, 1'b0);
      nxt(1'b1, 4'hF);
      chk("undef_sticky", State, 4'hF);
      reset = 1'b0;
      #1;
      chk("undef_rst_fault", Fault, 1'b0);
      chk("undef_rst_state", State, 4'h0);
      release_reset(1'b0);

      // FETCH timeout: fault after the 4th waiting cycle
      chk("to_wait1", State, 4'h0);
      chk("to_wait1_req", MemReq, 1'b1);
      chk("to_wait1_irw", IRWrite, 1'b0);
      chk("to_wait1_pcw", PCWrite, 1'b0);
      for (int i = 0; i < 3; i++) begin
         nxt(1'b0, 4'hF);
         chk("to_wait_n", State, 4'h0);
      end
      nxt(1'b1, 4'hF);
      chk("to_fault_state", State, 4'hF);
      chk("to_fault_flag", Fault, 1'b1);
      chk("to_fault_req", MemReq, 1'b0);
      chk("to_fault_irw", IRWrite, 1'b0);
      chk("to_fault_pcw", PCWrite, 1'b0);
      chk("to_fault_we", MemWrite, 1'b0);
      nxt(1'b1, 4'hF);
      chk("to_fault_sticky", State, 4'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
